// File: rtl/bin_to_bcd_digits.sv
// Sequential double-dabble binary-to-BCD converter feeding the 7-segment
// digit decoders. Optionally blanks leading zero digits with 4'hF.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; digits holds the last result
//   SHIFT  | one add-3/shift iteration per clock, WIDTH iterations total
//   FINISH | load the (blanked) result into digits, pulse done
module bin_to_bcd_digits #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic [4*DIGITS-1:0] digits
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // The BCD field must hold the largest WIDTH-bit value.
  function automatic bit digits_ok();
    longint unsigned p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  if (!digits_ok()) begin : g_bad_digits
    $error("bin_to_bcd_digits: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   bcd_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;

  // Per-nibble add-3 correction; nibbles are independent, no carry between them.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Replace zeros above the first nonzero digit with 4'hF; digit 0 always shows.
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = BLANK_LZ;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (b[4*k +: 4] == 4'h0)) r[4*k +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd_q);

  // State, datapath and output registers; reset blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '1;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        digits_d = blank_lz(bcd_q);
        done_d   = 1'b1;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign valid  = valid_q;
  assign digits = digits_q;

endmodule
